seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Monitor-side decoder for the team's multiplexed 4-digit seven-segment display interface. It samples the scanned segment lines (a..g) and anode selects (A) exactly as the display driver `top` emits them, then decodes each stable digit back to a hex nibble. It reassembles the 16-bit value once all four digits have been seen. It sits beside the display driver in self-checking benches and on-board loopback, closing the loop from the displayed value back to a register.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples (anode + segments) required before a digit is accepted; range 1..255.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  enable. 0 freezes all state; outputs hold.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`  in  1 each  segment lines, active-low (0 = lit).
- `A`  in  4  anode selects, active-low. `A[0]` is the least-significant digit, nibble [3:0].
- `value`  out  16  last complete reassembled value.
- `valid`  out  1  high once at least one complete frame has been captured since reset.
- `frame_done`  out  1  one-cycle pulse when `value` updates.
- `err`  out  1  sticky error: an illegal segment pattern, or more than one anode active and held stable.

## Operation
- Input stage: {A, a..g} registered once into `smp`. All decisions use `smp` and the previous sample `smp_q`.
- Segment decode (active-high form, order a..g, MSB = a):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern is illegal.
- FSM states:
  - IDLE: no anode active, or sample changed. Stability counter cleared.
  - SETTLE: exactly one anode active and `smp == smp_q`. The counter increments each cycle.
  - HOLD: digit accepted. Stay here until the sample changes, so there is only one capture per anode activation.
- Transitions:
  - IDLE→SETTLE: exactly one anode active.
  - SETTLE→HOLD: counter reaches `STABLE_CYCLES-1` with the sample still unchanged.
  - SETTLE/HOLD→IDLE: any change in `smp`.
- Capture on SETTLE→HOLD:
  - Legal pattern: write the nibble to `digit[i]` and set `seen[i]`.
  - Illegal pattern: set `err`, write nothing.
- Frame complete when `seen == 4'b1111`. On the next cycle:
  - `value <= {digit[3],digit[2],digit[1],digit[0]}`.
  - `valid <= 1`, `frame_done` pulses, `seen` cleared.
- Multiple active anodes held stable for `STABLE_CYCLES` set `err` and capture nothing. All anodes off (blanking) means IDLE with no error.
- A re-capture of an already-seen digit before the frame completes overwrites `digit[i]`.

## Timing
- Reset values: `value`=0, `valid`=0, `frame_done`=0, `err`=0, `seen`=0, FSM=IDLE, counter=0, `smp`/`smp_q` = all-ones (nothing lit).
- Latency, pin change to capture: 1 cycle input register + `STABLE_CYCLES` cycles of stable sample. The digit is written on the edge ending SETTLE.
- Latency, fourth capture to `value`/`frame_done`: 1 cycle.
- Reset asserted mid-scan: everything cleared on that edge. Partial frames are discarded.
- `en`=0: no register changes, including `smp`. `frame_done` is forced low while disabled.
- Counter saturates; it never wraps.
- Digit capture in the same cycle as frame completion: the completing write is included in `value`.

## Configuration
- `SEG_CHANGE_DETECT_EN` defined:
  - Adds output `changed` (1 bit), which pulses together with `frame_done` only when the new `value` differs from the previous one.
  - The first frame after reset always pulses.
- Undefined: the port and its compare register are absent.

## Structure
- Package `seg_pkg`:
  - the 16 segment patterns as `localparam logic [6:0]` constants;
  - the FSM state enum;
  - the active-low polarity constants.
- One combinational sub-module, `seg7_to_hex`: 7-bit active-high pattern in → 4-bit nibble + `legal` flag out.

## Test plan
- Driver `top` loaded with 0x0132, en=1, STABLE_CYCLES=4 → within two full scan rotations `value`=0x0132, `valid`=1, one `frame_done` pulse per rotation, `err`=0.
- Hand-drive A=1110 with segments 0010010 (digit 2) held 2 cycles, then blank → nothing captured, `seen`=0.
- Drive all 16 legal patterns across the four anodes (0x89AB, then 0xCDEF) → `value` matches each in turn.
- Hold A=1100 for 10 cycles → `err`=1. Scanning continues and `value` still updates correctly.
- Mid-scan with three digits seen, pulse `rst` → all outputs 0. The next full rotation yields the correct value.
- With `SEG_CHANGE_DETECT_EN`, repeat 0x0132 over three frames, then load 0x0133 → `changed` pulses on frame 1 and on the first 0x0133 frame only.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns, polarity constants and FSM states for seg_scan_decoder
package seg_pkg;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  localparam logic SEG_ON = 1'b0;
  localparam logic AN_ON = 1'b0;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: active-high a..g pattern (seg[6]=a) -> nib, legal=0 for unknown patterns
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       legal
);
  always_comb begin
    nib = 4'h0;
    legal = 1'b1;
    case (seg)
      SEG_0: nib = 4'h0;
      SEG_1: nib = 4'h1;
      SEG_2: nib = 4'h2;
      SEG_3: nib = 4'h3;
      SEG_4: nib = 4'h4;
      SEG_5: nib = 4'h5;
      SEG_6: nib = 4'h6;
      SEG_7: nib = 4'h7;
      SEG_8: nib = 4'h8;
      SEG_9: nib = 4'h9;
      SEG_A: nib = 4'hA;
      SEG_B: nib = 4'hB;
      SEG_C: nib = 4'hC;
      SEG_D: nib = 4'hD;
      SEG_E: nib = 4'hE;
      SEG_F: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a scanned 4-digit seven-segment bus back into a 16-bit value
// ports: clk, rst (sync high), en, a..g/A (active-low pins) -> value, valid, frame_done, err
// SEG_CHANGE_DETECT_EN adds output changed: pulses with frame_done when value differs
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic [3:0]  A,
  output logic [15:0] value,
  output logic        valid,
  output logic        frame_done,
  output logic        err
`ifdef SEG_CHANGE_DETECT_EN
  ,
  output logic        changed
`endif
);
  logic [10:0] smp, smp_q;
  state_t state;
  logic [7:0] cnt;
  logic [3:0] seen;
  logic [3:0] digit [4];
  logic [3:0] d_nxt [4];
  logic fd_r;
  logic [3:0] act, nib, cap_mask;
  logic [6:0] seg_hi;
  logic [1:0] idx;
  logic same, any, legal, accept, cap, bad;
  logic [15:0] packed_nxt;
  assign act = smp[10:7] ^ {4{~AN_ON}};
  assign seg_hi = smp[6:0] ^ {7{~SEG_ON}};
  assign same = smp == smp_q;
  assign any = |act;
  assign idx = act[1] ? 2'd1 : act[2] ? 2'd2 : act[3] ? 2'd3 : 2'd0;
  seg7_to_hex u_dec (.seg(seg_hi), .nib(nib), .legal(legal));
  // Any lit anode pattern is timed; the acceptance decides capture versus error, so a
  // stable multi-anode drive is flagged after exactly the same settle time as a digit.
  assign accept = state != HOLD && same && any && 32'(cnt) + 32'd1 >= STABLE_CYCLES;
  assign cap = accept && $onehot(act) && legal;
  assign bad = accept && !($onehot(act) && legal);
  assign cap_mask = cap ? 4'b0001 << idx : 4'b0000;
  // Next digit contents, so a capture landing on the frame-completion edge is included.
  always_comb begin
    for (int j = 0; j < 4; j++) d_nxt[j] = cap_mask[j] ? nib : digit[j];
  end
  assign packed_nxt = {d_nxt[3], d_nxt[2], d_nxt[1], d_nxt[0]};
  assign frame_done = fd_r & en;
`ifdef SEG_CHANGE_DETECT_EN
  logic ch_r;
  assign changed = ch_r & en;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= '1;
      smp_q <= '1;
      state <= IDLE;
      cnt <= '0;
      seen <= '0;
      value <= '0;
      valid <= 1'b0;
      fd_r <= 1'b0;
      err <= 1'b0;
      for (int j = 0; j < 4; j++) digit[j] <= '0;
`ifdef SEG_CHANGE_DETECT_EN
      ch_r <= 1'b0;
`endif
    end else if (en) begin
      smp_q <= smp;
      smp <= {A, a, b, c, d, e, f, g};
      state <= !same ? IDLE : accept ? HOLD : state == HOLD ? HOLD : any ? SETTLE : IDLE;
      cnt <= (!same || !any || accept || state == HOLD) ? 8'd0 : cnt == 8'hFF ? cnt : cnt + 8'd1;
      err <= err | bad;
      for (int j = 0; j < 4; j++) digit[j] <= d_nxt[j];
      fd_r <= seen == 4'hF;
`ifdef SEG_CHANGE_DETECT_EN
      ch_r <= seen == 4'hF && (!valid || packed_nxt != value);
`endif
      if (seen == 4'hF) begin
        value <= packed_nxt;
        valid <= 1'b1;
        seen <= '0;
      end else begin
        seen <= seen | cap_mask;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and randomized scans checked against a digit-level model
module tb_seg_scan_decoder;
  localparam int S = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [6:0] segs = '1;
  logic [3:0] an = '1;
  logic [15:0] value;
  logic valid, frame_done, err, changed;
  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int errors = 0, checks = 0, fd_cnt = 0, ch_cnt = 0;
  logic [3:0] m_dig [4];
  logic [3:0] m_seen = '0;
  logic [15:0] m_val = '0;
  logic m_valid = 1'b0, m_err = 1'b0;
  int m_frames = 0, m_changes = 0;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a(segs[6]), .b(segs[5]), .c(segs[4]), .d(segs[3]), .e(segs[2]), .f(segs[1]), .g(segs[0]),
    .A(an), .value(value), .valid(valid), .frame_done(frame_done), .err(err)
`ifdef SEG_CHANGE_DETECT_EN
    , .changed(changed)
`endif
  );
`ifndef SEG_CHANGE_DETECT_EN
  assign changed = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (changed) ch_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic hold(input logic [3:0] anv, input logic [6:0] pins, input int n);
    an = anv;
    segs = pins;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    hold(4'hF, 7'h7F, n);
  endtask

  task automatic model_frame();
    logic [15:0] nv;
    nv = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    if (!m_valid || nv != m_val) m_changes++;
    m_val = nv;
    m_valid = 1'b1;
    m_frames++;
    m_seen = '0;
  endtask

  // A digit is taken once its pins stay put for the input register plus S stable samples.
  task automatic show(input int i, input logic [3:0] nib, input int dwell);
    hold(~(4'b0001 << i), ~pat[nib], dwell);
    if (dwell >= S + 1) begin
      m_dig[i] = nib;
      m_seen[i] = 1'b1;
      if (&m_seen) model_frame();
    end
  endtask

  task automatic rotate(input logic [15:0] v, input bit rnd);
    int dw;
    for (int i = 0; i < 4; i++) begin
      if (!rnd) dw = S + 2;
      else if ($urandom_range(0, 4) == 0) dw = $urandom_range(1, S);
      else dw = $urandom_range(S + 1, S + 5);
      show(i, v[i*4 +: 4], dw);
      blank(rnd ? $urandom_range(1, 3) : 1);
    end
  endtask

  task automatic check_state(input string tag);
    blank(4);
    chk({tag, ".value"}, 32'(value), 32'(m_val));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".frames"}, fd_cnt, m_frames);
`ifdef SEG_CHANGE_DETECT_EN
    chk({tag, ".changed"}, ch_cnt, m_changes);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst.value", 32'(value), 0);
    chk("rst.valid", 32'(valid), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.frame_done", 32'(frame_done), 0);
    chk("rst.seen", 32'(dut.seen), 0);
    rst = 1'b0;
    m_seen = '0;
    m_val = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    blank(2);
    do_reset();
    rotate(16'h0132, 1'b0);
    rotate(16'h0132, 1'b0);
    check_state("scan0132");
    show(0, 4'h2, 2);
    blank(4);
    chk("short.seen", 32'(dut.seen), 0);
    check_state("short");
    rotate(16'h89AB, 1'b0);
    check_state("pat89AB");
    rotate(16'hCDEF, 1'b0);
    check_state("patCDEF");
    hold(4'b1100, ~pat[1], 10);
    m_err = 1'b1;
    check_state("multi");
    rotate(16'h5A3C, 1'b0);
    check_state("after_multi");
    show(0, 4'h9, S + 2);
    blank(1);
    show(1, 4'h8, S + 2);
    blank(1);
    show(2, 4'h7, S + 2);
    blank(1);
    do_reset();
    rotate(16'h7E41, 1'b0);
    check_state("after_rst");
    hold(4'b1110, ~7'b0000001, 8);
    m_err = 1'b1;
    check_state("illegal");
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hold(~(4'b0001 << i), ~pat[4'h6], 12);
      blank(2);
    end
    chk("dis.frame_done", 32'(frame_done), 0);
    chk("dis.value", 32'(value), 32'(m_val));
    en = 1'b1;
    blank(3);
    check_state("disabled");
    rotate(16'h0132, 1'b0);
    rotate(16'h0132, 1'b0);
    rotate(16'h0132, 1'b0);
    rotate(16'h0133, 1'b0);
    check_state("chg");
    for (int k = 0; k < 25; k++) begin
      rotate(16'($urandom), 1'b1);
      check_state("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
